axi_lite_arb2_ctrl: RTL and testbench
=====================================

Name: axi_lite_arb2_ctrl

Overview:
- Two-requester arbiter/sequencer in front of the single-beat AXI-Lite memory slave: sequences AW/W/B and AR/R handshakes.
- Shares one slave port between two simple request/done clients (e.g. CPU bridge, DMA) using round-robin.
- One transaction in flight at a time; all AXI outputs registered.

Parameters:
- TIMEOUT_CYCLES, 255, wait-state cycles before abort; used only with ARB_TIMEOUT_EN; 8-bit range 1..255.
- RESET_PRIORITY, 0, requester that wins the first simultaneous request after reset (0 or 1).

Ports:
- ACLK  in  1  clock; all logic on posedge.
- ARESET  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  request pending; held high until REQ0_DONE.
- REQ0_WRITE  in  1  1 = write, 0 = read.
- REQ0_ADDR  in  32  byte address, passed unchanged.
- REQ0_WDATA  in  32  write data.
- REQ0_WSTRB  in  4  byte strobes.
- REQ0_DONE  out  1  one-cycle completion pulse.
- REQ0_RDATA  out  32  read data; valid with DONE, held until the next read completes for requester 0.
- REQ0_ERR  out  1  error status; valid with DONE.
- REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA, REQ1_WSTRB, REQ1_DONE, REQ1_RDATA, REQ1_ERR: identical to the REQ0 set, for requester 1.
- AWADDR out 32, AWVALID out 1, AWREADY in 1: write address channel.
- WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1: write data channel.
- BRESP in 1, BVALID in 1, BREADY out 1: write response channel (1-bit response, 0 = OK).
- ARADDR out 32, ARVALID out 1, ARREADY in 1: read address channel.
- RDATA in 32, RVALID in 1, RREADY out 1: read data channel.

Behaviour:
- Reset: all outputs 0, state IDLE, aw_done/w_done flags 0. last_grant resets to the requester opposite RESET_PRIORITY.
- Reset asserted mid-transaction: immediate return to IDLE, all VALID/READY outputs 0, no DONE pulse.
- IDLE, one VALID high: grant that requester. Both high: grant the requester that is not last_grant.
- At grant, latch WRITE/ADDR/WDATA/WSTRB into internal registers. Later requester input changes, including VALID dropping, are ignored; the transaction completes and DONE still pulses.
- Next state from IDLE: WADDR if write, RADDR if read.
- WADDR:
  - AWVALID = WVALID = 1 from the cycle after grant.
  - Each channel deasserts its VALID the cycle after its own handshake (VALID & READY) and sets aw_done / w_done.
  - Handshakes may complete in either order or in the same cycle.
  - Move to WRESP when both are done.
- WRESP: BREADY = 1. On BVALID, capture BRESP as ERR, drop BREADY, move to DONE.
- RADDR: ARVALID = 1 until the ARREADY handshake, then move to RDATA.
- RDATA: RREADY = 1. On RVALID, capture RDATA, set ERR = 0, drop RREADY, move to DONE.
- DONE:
  - Pulse the granted REQn_DONE for exactly one cycle with REQn_ERR (and REQn_RDATA for reads).
  - Set last_grant to the granted requester; return to IDLE.
- Back-to-back: the earliest new grant is in the IDLE cycle after DONE, so there is one idle cycle minimum between transactions.
- Writes never modify REQn_RDATA. REQn_ERR is held until that requester's next DONE.
- AXI outputs never change while VALID is high and READY is low (AXI stability rule).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on every state entry and increments each cycle spent in WADDR, WRESP, RADDR or RDATA.
  - On reaching TIMEOUT_CYCLES: drop all AXI VALID/READY outputs, go to DONE, pulse DONE with ERR = 1. REQn_RDATA is unchanged on a timed-out read.
- Undefined: no counter; wait states wait indefinitely.

Test Plan:
- Req0 write addr 0x4, WDATA 0xA1B2C3D4, WSTRB 0xF; slave AWREADY/WREADY same cycle, BRESP 0 -> AWADDR = 0x4, one AW and one W handshake, REQ0_DONE single pulse, REQ0_ERR = 0.
- Req1 read addr 0x4 after the above; slave returns RDATA 0x000000D4 after 3 wait cycles -> ARVALID held 1 until ARREADY, REQ1_DONE pulse with REQ1_RDATA = 0x000000D4, REQ1_ERR = 0.
- REQ0_VALID and REQ1_VALID rise together, both held, RESET_PRIORITY = 0 -> grant order 0, 1, 0, 1 over four transactions; never two grants to one requester while the other waits.
- WREADY 4 cycles before AWREADY, then BRESP = 1 -> WVALID drops after its handshake, AWVALID stays 1 until AWREADY, REQn_ERR = 1.
- ARESET pulled low in RDATA state with RVALID never given -> all outputs 0 immediately, no DONE; next request serviced normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, AWREADY tied 0 -> AWVALID drops after 16 cycles, DONE pulses with ERR = 1, controller returns to IDLE.

Source files
------------

// File: rtl/axi_lite_arb2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arb2_ctrl
// Description : Two-requester round-robin arbiter/sequencer that drives a
//               single-beat AXI-Lite slave port (AW/W/B and AR/R).
//               One transaction in flight; all AXI outputs registered.
//               Optional wait-state abort: define ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arb2_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_PRIORITY = 0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // requester 0
  input  logic        REQ0_VALID,
  input  logic        REQ0_WRITE,
  input  logic [31:0] REQ0_ADDR,
  input  logic [31:0] REQ0_WDATA,
  input  logic [3:0]  REQ0_WSTRB,
  output logic        REQ0_DONE,
  output logic [31:0] REQ0_RDATA,
  output logic        REQ0_ERR,
  // requester 1
  input  logic        REQ1_VALID,
  input  logic        REQ1_WRITE,
  input  logic [31:0] REQ1_ADDR,
  input  logic [31:0] REQ1_WDATA,
  input  logic [3:0]  REQ1_WSTRB,
  output logic        REQ1_DONE,
  output logic [31:0] REQ1_RDATA,
  output logic        REQ1_ERR,
  // AXI-Lite master port
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  output logic        RREADY
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_WADDR = 3'd1;
  localparam logic [2:0] c_S_WRESP = 3'd2;
  localparam logic [2:0] c_S_RADDR = 3'd3;
  localparam logic [2:0] c_S_RDATA = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;

  // last_grant starts opposite the favoured requester so that it wins the
  // first tie after reset
  localparam logic c_LAST_RST = (RESET_PRIORITY == 0) ? 1'b1 : 1'b0;

  // An out-of-range timeout value elaborates this empty block, which makes
  // the mistake visible in the elaborated hierarchy; legal values never do.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_out_of_range
  end

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_gnt;
  logic        r_last;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_done0;
  logic        r_done1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic w_any;
  logic w_sel1;
  logic w_sel_write;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_tmo;
  logic w_finish;
  logic w_fin_err;
  logic w_fin_rd;

  // Round-robin pick: a lone request wins; on a tie, the one not served last
  assign w_any       = REQ0_VALID | REQ1_VALID;
  assign w_sel1      = REQ1_VALID & (~REQ0_VALID | ~r_last);
  assign w_sel_write = w_sel1 ? REQ1_WRITE : REQ0_WRITE;

  assign w_aw_hs  = r_awvalid & AWREADY;
  assign w_w_hs   = r_wvalid & WREADY;
  assign w_b_hs   = r_bready & BVALID;
  assign w_ar_hs  = r_arvalid & ARREADY;
  assign w_r_hs   = r_rready & RVALID;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo_cnt;
  logic       w_wait_state;

  assign w_wait_state = (r_state == c_S_WADDR) || (r_state == c_S_WRESP) ||
                        (r_state == c_S_RADDR) || (r_state == c_S_RDATA);
  assign w_tmo        = w_wait_state && (r_tmo_cnt == c_TMO_LAST);

  // Wait-state counter: restarts on every state change, counts wait cycles
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_wait_state) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state and completion decode; a real handshake always beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    w_fin_err   = 1'b0;
    w_fin_rd    = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (w_any) w_state_nxt = w_sel_write ? c_S_WADDR : c_S_RADDR;
      end
      c_S_WADDR: begin
        if (w_aw_fin && w_w_fin) begin
          w_state_nxt = c_S_WRESP;
        end else if (w_tmo) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
        end
      end
      c_S_WRESP: begin
        if (w_b_hs) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_err   = BRESP;
        end else if (w_tmo) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
        end
      end
      c_S_RADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = c_S_RDATA;
        end else if (w_tmo) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
        end
      end
      c_S_RDATA: begin
        if (w_r_hs) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_rd    = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = c_S_DONE;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
        end
      end
      c_S_DONE: w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // Sequencer: grant capture and AXI VALID/READY generation
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state   <= c_S_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= c_LAST_RST;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_sel1;
            r_addr    <= w_sel1 ? REQ1_ADDR  : REQ0_ADDR;
            r_wdata   <= w_sel1 ? REQ1_WDATA : REQ0_WDATA;
            r_wstrb   <= w_sel1 ? REQ1_WSTRB : REQ0_WSTRB;
            r_awvalid <= w_sel_write;
            r_wvalid  <= w_sel_write;
            r_arvalid <= ~w_sel_write;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        c_S_WADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) r_bready <= 1'b1;
        end
        c_S_RADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        c_S_DONE: begin
          r_last    <= r_gnt;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        default: ;
      endcase
      // Any completion (normal or abort) leaves every channel idle
      if (w_finish) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
      end
    end
  end

  // Requester status: DONE pulses during the DONE state; ERR/RDATA are held
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_done0 <= w_finish & ~r_gnt;
      r_done1 <= w_finish & r_gnt;
      if (w_finish && !r_gnt) begin
        r_err0 <= w_fin_err;
        if (w_fin_rd) r_rdata0 <= RDATA;
      end
      if (w_finish && r_gnt) begin
        r_err1 <= w_fin_err;
        if (w_fin_rd) r_rdata1 <= RDATA;
      end
    end
  end

  assign AWADDR     = r_addr;
  assign AWVALID    = r_awvalid;
  assign WDATA      = r_wdata;
  assign WSTRB      = r_wstrb;
  assign WVALID     = r_wvalid;
  assign BREADY     = r_bready;
  assign ARADDR     = r_addr;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;
  assign REQ0_DONE  = r_done0;
  assign REQ0_ERR   = r_err0;
  assign REQ0_RDATA = r_rdata0;
  assign REQ1_DONE  = r_done1;
  assign REQ1_ERR   = r_err1;
  assign REQ1_RDATA = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arb2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arb2_ctrl
// Description : Scoreboard bench for axi_lite_arb2_ctrl with a small
//               configurable AXI-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arb2_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        REQ0_VALID, REQ0_WRITE, REQ1_VALID, REQ1_WRITE;
  logic [31:0] REQ0_ADDR, REQ0_WDATA, REQ1_ADDR, REQ1_WDATA;
  logic [3:0]  REQ0_WSTRB, REQ1_WSTRB;
  logic        REQ0_DONE, REQ0_ERR, REQ1_DONE, REQ1_ERR;
  logic [31:0] REQ0_RDATA, REQ1_RDATA;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BRESP, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  axi_lite_arb2_ctrl #(.TIMEOUT_CYCLES(16), .RESET_PRIORITY(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_WSTRB(REQ0_WSTRB), .REQ0_DONE(REQ0_DONE),
    .REQ0_RDATA(REQ0_RDATA), .REQ0_ERR(REQ0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_WSTRB(REQ1_WSTRB), .REQ1_DONE(REQ1_DONE),
    .REQ1_RDATA(REQ1_RDATA), .REQ1_ERR(REQ1_ERR),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rd;
  } done_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  done_t       q_done[$];
  logic [31:0] q_aw[$];
  logic [35:0] q_w[$];
  logic [31:0] q_ar[$];
  logic [31:0] exp_rd0, exp_rd1;

  // slave model configuration
  int          aw_dly = 0, w_dly = 0, r_dly = 0;
  bit          aw_never = 1'b0, r_never = 1'b0;
  logic        bresp_cfg = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_lat = 32'd0;
  int          aw_c = 0, w_c = 0, r_c = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected / not reached", name);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, REQ0_DONE, REQ1_DONE,
                   REQ0_ERR, REQ1_ERR, |AWADDR, |WDATA, |WSTRB, |ARADDR,
                   |REQ0_RDATA, |REQ1_RDATA}), 64'd0);
  endtask

  // Slave model: each READY rises after its configured number of VALID cycles
  initial begin : slave
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'd0;
    forever begin
      @(posedge ACLK); #1;
      AWREADY = AWVALID && !aw_never && (aw_c >= aw_dly);
      aw_c    = AWVALID ? aw_c + 1 : 0;
      WREADY  = WVALID && (w_c >= w_dly);
      w_c     = WVALID ? w_c + 1 : 0;
      BVALID  = BREADY;
      BRESP   = BREADY ? bresp_cfg : 1'b0;
      if (ARVALID) ar_lat = ARADDR;
      ARREADY = ARVALID;
      RVALID  = RREADY && !r_never && (r_c >= r_dly);
      r_c     = RREADY ? r_c + 1 : 0;
      RDATA   = RVALID ? (mem.exists(ar_lat) ? mem[ar_lat] : 32'hDEAD_BEEF) : 32'd0;
    end
  end

  // Monitor: AXI stability, handshake payloads and DONE responses
  initial begin : monitor
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    done_t       e;
    logic        id;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        if (p_awv && !p_awr) chk("aw_stable", 64'({AWVALID, AWADDR}), 64'({1'b1, p_awaddr}));
        if (p_wv && !p_wr)   chk("w_stable", 64'({WVALID, WDATA, WSTRB}), 64'({1'b1, p_wdata, p_wstrb}));
        if (p_arv && !p_arr) chk("ar_stable", 64'({ARVALID, ARADDR}), 64'({1'b1, p_araddr}));
        if (AWVALID && AWREADY) begin
          if (q_aw.size() == 0) flag("aw_extra_handshake");
          else chk("aw_addr", 64'(AWADDR), 64'(q_aw.pop_front()));
        end
        if (WVALID && WREADY) begin
          if (q_w.size() == 0) flag("w_extra_handshake");
          else chk("w_data_strb", 64'({WDATA, WSTRB}), 64'(q_w.pop_front()));
        end
        if (ARVALID && ARREADY) begin
          if (q_ar.size() == 0) flag("ar_extra_handshake");
          else chk("ar_addr", 64'(ARADDR), 64'(q_ar.pop_front()));
        end
        if (REQ0_DONE || REQ1_DONE) begin
          done_seen++;
          if (REQ0_DONE && REQ1_DONE) flag("dual_done");
          else if (q_done.size() == 0) flag("unexpected_done");
          else begin
            e  = q_done.pop_front();
            id = REQ1_DONE;
            chk("done_id", 64'(id), 64'(e.id));
            chk("done_err", 64'(id ? REQ1_ERR : REQ0_ERR), 64'(e.err));
            chk("done_rdata", 64'(id ? REQ1_RDATA : REQ0_RDATA), 64'(e.rd));
          end
        end
      end
      p_awv = AWVALID && ARESET; p_awr = AWREADY; p_awaddr = AWADDR;
      p_wv  = WVALID && ARESET;  p_wr  = WREADY;  p_wdata = WDATA; p_wstrb = WSTRB;
      p_arv = ARVALID && ARESET; p_arr = ARREADY; p_araddr = ARADDR;
    end
  end

  task automatic set_req(input bit id, input bit valid, input bit write,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    if (id == 1'b0) begin
      REQ0_VALID = valid; REQ0_WRITE = write; REQ0_ADDR = addr;
      REQ0_WDATA = wdata; REQ0_WSTRB = wstrb;
    end else begin
      REQ1_VALID = valid; REQ1_WRITE = write; REQ1_ADDR = addr;
      REQ1_WDATA = wdata; REQ1_WSTRB = wstrb;
    end
  endtask

  task automatic push_done(input bit id, input bit err, input logic [31:0] rd);
    done_t d;
    d.id = id; d.err = err; d.rd = rd;
    q_done.push_back(d);
  endtask

  // Wait (bounded) for the DONE count to reach target, then return #1 after
  // the following posedge so requester inputs can be dropped before IDLE.
  task automatic wait_done(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK); #1;
      if (done_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag(name);
    @(posedge ACLK); #1;
  endtask

  task automatic drained(input string name);
    chk(name, 64'(q_aw.size() + q_w.size() + q_ar.size() + q_done.size()), 64'd0);
  endtask

  initial begin : stim
    int tgt;
    bit ok;
    set_req(0, 0, 0, 32'd0, 32'd0, 4'd0);
    set_req(1, 0, 0, 32'd0, 32'd0, 4'd0);
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    mem[32'h4]  = 32'h0000_00D4;
    mem[32'h10] = 32'h1111_2222;
    mem[32'h20] = 32'h3333_4444;
    repeat (3) @(posedge ACLK);
    #1;
    check_all_zero("reset_outputs");
    ARESET = 1'b1;
    @(posedge ACLK); #1;

    // 1: requester 0 write, both ready at once, OKAY response
    q_aw.push_back(32'h4);
    q_w.push_back({32'hA1B2_C3D4, 4'hF});
    push_done(0, 0, exp_rd0);
    tgt = done_seen + 1;
    set_req(0, 1, 1, 32'h4, 32'hA1B2_C3D4, 4'hF);
    wait_done(tgt, "t1_done_timeout");
    set_req(0, 0, 0, 32'd0, 32'd0, 4'd0);
    drained("t1_drained");

    // 2: requester 1 read, RVALID after 3 wait cycles
    r_dly = 3;
    q_ar.push_back(32'h4);
    exp_rd1 = 32'h0000_00D4;
    push_done(1, 0, exp_rd1);
    tgt = done_seen + 1;
    set_req(1, 1, 0, 32'h4, 32'd0, 4'd0);
    wait_done(tgt, "t2_done_timeout");
    set_req(1, 0, 0, 32'd0, 32'd0, 4'd0);
    drained("t2_drained");

    // 3: both held -> strict alternation 0,1,0,1
    r_dly = 0;
    exp_rd0 = 32'h1111_2222;
    exp_rd1 = 32'h3333_4444;
    for (int k = 0; k < 2; k++) begin
      q_ar.push_back(32'h10); push_done(0, 0, exp_rd0);
      q_ar.push_back(32'h20); push_done(1, 0, exp_rd1);
    end
    tgt = done_seen + 4;
    set_req(0, 1, 0, 32'h10, 32'd0, 4'd0);
    set_req(1, 1, 0, 32'h20, 32'd0, 4'd0);
    wait_done(tgt, "t3_done_timeout");
    set_req(0, 0, 0, 32'd0, 32'd0, 4'd0);
    set_req(1, 0, 0, 32'd0, 32'd0, 4'd0);
    drained("t3_drained");

    // 4: W accepted 4 cycles before AW, SLVERR; inputs scrambled after grant
    aw_dly = 4; w_dly = 0; bresp_cfg = 1'b1;
    q_aw.push_back(32'h8);
    q_w.push_back({32'h1234_5678, 4'h3});
    push_done(1, 1, exp_rd1);
    tgt = done_seen + 1;
    set_req(1, 1, 1, 32'h8, 32'h1234_5678, 4'h3);
    repeat (2) @(posedge ACLK);
    #1;
    set_req(1, 0, 0, 32'hFFFF_FFFC, 32'd0, 4'd0);
    wait_done(tgt, "t4_done_timeout");
    aw_dly = 0; bresp_cfg = 1'b0;
    drained("t4_drained");

    // 5: reset while waiting in RDATA
    r_never = 1'b1;
    q_ar.push_back(32'h4);
    set_req(1, 1, 0, 32'h4, 32'd0, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (RREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("t5_rready_timeout");
    ARESET = 1'b0;
    #1;
    check_all_zero("reset_midflight");
    repeat (3) @(posedge ACLK);
    #1;
    set_req(1, 0, 0, 32'd0, 32'd0, 4'd0);
    r_never = 1'b0;
    ARESET = 1'b1;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    drained("t5_drained");

    // 6: normal service after reset
    r_dly = 1;
    q_ar.push_back(32'h4);
    exp_rd0 = 32'h0000_00D4;
    push_done(0, 0, exp_rd0);
    tgt = done_seen + 1;
    set_req(0, 1, 0, 32'h4, 32'd0, 4'd0);
    wait_done(tgt, "t6_done_timeout");
    set_req(0, 0, 0, 32'd0, 32'd0, 4'd0);
    q_aw.push_back(32'hC);
    q_w.push_back({32'hCAFE_F00D, 4'hF});
    push_done(1, 0, exp_rd1);
    tgt = done_seen + 1;
    set_req(1, 1, 1, 32'hC, 32'hCAFE_F00D, 4'hF);
    wait_done(tgt, "t6b_done_timeout");
    set_req(1, 0, 0, 32'd0, 32'd0, 4'd0);
    drained("t6_drained");

`ifdef ARB_TIMEOUT_EN
    // 7: AWREADY never comes -> abort after 16 wait cycles with ERR
    begin
      int awv_cycles;
      aw_never = 1'b1;
      q_w.push_back({32'h5555_AAAA, 4'hF});
      push_done(0, 1, exp_rd0);
      tgt = done_seen + 1;
      awv_cycles = 0;
      set_req(0, 1, 1, 32'h40, 32'h5555_AAAA, 4'hF);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge ACLK); #1;
        if (AWVALID) awv_cycles++;
        if (done_seen >= tgt) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) flag("t7_done_timeout");
      chk("tmo_awvalid_cycles", 64'(awv_cycles), 64'd16);
      @(posedge ACLK); #1;
      set_req(0, 0, 0, 32'd0, 32'd0, 4'd0);
      aw_never = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      chk("tmo_idle_valids", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
      drained("t7_drained");
    end
`endif

    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
